qtable_update_ctrl: RTL and testbench
=====================================

Name: qtable_update_ctrl

Overview:
- Sequences one Q-learning update against the single-read/single-write Q-table BRAM (registered read, 1-cycle latency).
- Per accepted request (s, a, s'), it reads all NUM_ACT entries of s' and tracks the IEEE-754 maximum and its argmax. It then reads Q(s,a).
- It hands Q(s,a) and max Q(s',·) to the external float update datapath over a valid/ready handshake, waits for the new value, and writes it back to {s,a}.

Parameters:
- STATE_W, 6, state index width.
- ACT_W, 2, action index width; NUM_ACT = 2**ACT_W.
- ADDR_WIDTH, 9, Q-table address width; must be >= STATE_W+ACT_W.
- DATA_WIDTH, 32, Q-value width (IEEE-754 single).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  1  update request valid.
- o_req_ready  out  1  high only in IDLE.
- i_state  in  STATE_W  current state s.
- i_action  in  ACT_W  taken action a.
- i_next_state  in  STATE_W  next state s'.
- o_q_addr_r  out  ADDR_WIDTH  table read address.
- o_q_read_en  out  1  table read enable.
- i_q_rdata  in  DATA_WIDTH  table read data; valid the cycle after o_q_read_en.
- o_q_addr_w  out  ADDR_WIDTH  table write address.
- o_q_write_en  out  1  table write enable.
- o_q_wdata  out  DATA_WIDTH  table write data.
- o_upd_valid  out  1  operands valid to the update datapath.
- i_upd_ready  in  1  datapath accepts operands.
- o_q_sa  out  DATA_WIDTH  Q(s,a).
- o_q_max_next  out  DATA_WIDTH  max over a' of Q(s',a').
- o_max_action  out  ACT_W  argmax a'.
- i_res_valid  in  1  new Q value valid.
- i_res_data  in  DATA_WIDTH  new Q value.
- o_busy  out  1  high whenever not in IDLE.
- o_done  out  1  1-cycle pulse coincident with the write.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE. Every output is 0 except o_req_ready=1.
- Address is the zero-extended {state, action}.
- States: IDLE -> RD -> CAP -> ISSUE -> WAIT_RES -> WR -> IDLE.
- IDLE: when i_req_valid && o_req_ready (cycle 0), latch s, a, s'; go to RD.
- RD, cycles 1..NUM_ACT+1:
  - o_q_read_en=1 each cycle.
  - Address {s',0}..{s',NUM_ACT-1}, then {s,a}.
  - Data returned in cycles 2..NUM_ACT+1 feeds the max tracker.
- CAP, cycle NUM_ACT+2: capture i_q_rdata as Q(s,a); read_en=0.
- ISSUE, from cycle NUM_ACT+3:
  - o_upd_valid=1; operands are held stable until i_upd_ready.
  - On the handshake cycle, go to WAIT_RES.
- WAIT_RES: on i_res_valid, latch i_res_data; go to WR. i_res_valid is ignored in every other state.
- WR, single cycle: o_q_write_en=1, o_q_addr_w={s,a}, o_q_wdata=latched result, o_done=1. Next state IDLE.
- Minimum request-to-write latency: NUM_ACT+5 cycles (9 at defaults), with immediate ready and result.
- Float max:
  - Key = sign ? ~x : x ^ MSB-mask; compare keys unsigned.
  - The first element initialises the running max.
  - Replace only on strictly greater key, so ties keep the lowest action index.
  - +0 beats -0. NaN is unsupported and yields an undefined order, but never a hang.
- Read and write are never issued in the same cycle, so there is no read-during-write hazard.
- o_q_max_next and o_max_action stay valid from ISSUE until the next request is accepted.
- a == any a' with s == s' is legal; the values read are pre-update.
- Reset mid-operation: immediate return to IDLE; no write issued; table contents untouched.

Decomposition:
- Package qlearn_pkg holds:
  - STATE_W/ACT_W/NUM_ACT/DATA_WIDTH defaults.
  - The FSM state enum encodings.
  - The float-to-orderable-key function.
- One sub-module, fp_max_tracker: clear/valid/data in; registered max and argmax out; counts the element index internally.

Test Plan:
- Basic update: s=3, a=2, s'=5; table {5,0..3} = 1.0, 4.0, 2.0, -3.0 (0x3F800000, 0x40800000, 0x40000000, 0xC0400000); Q(3,2)=0.5 -> o_q_max_next=0x40800000, o_max_action=1, o_q_sa=0x3F000000. Result 0x3FC00000 -> write addr 0x0E; o_done at cycle 9.
- All-negative with tie: s' entries -2.0, -1.0, -1.0, -5.0 -> max=0xBF800000, argmax=1 (lowest index on tie).
- Signed zero: entries -0.0, +0.0, -0.0, -0.0 -> max=0x00000000, argmax=1.
- Backpressure: hold i_upd_ready=0 for 5 cycles -> o_upd_valid and all operands stable. Assert i_res_valid early, while still in ISSUE -> ignored, no write. o_req_ready stays 0 throughout.
- Self-loop: s=s'=7, a=3 -> Q(7,3) read twice, pre-update values; back-to-back request accepted the cycle after o_done. The second update sees the first update's written value.
- Reset: deassert i_rst_n during WAIT_RES -> no o_q_write_en, target entry unchanged, o_req_ready=1 after release.

Source files
------------

// File: rtl/qlearn_pkg.sv
// qlearn_pkg: shared widths, update FSM encoding and float ordering key
package qlearn_pkg;
  localparam int STATE_W    = 6;
  localparam int ACT_W      = 2;
  localparam int NUM_ACT    = 1 << ACT_W;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_ISSUE,
    S_WAIT,
    S_WR
  } state_t;

  // Maps an IEEE-754 value onto an unsigned key with the same total order (+0 above -0)
  function automatic logic [DATA_WIDTH-1:0] fp_key(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-1] ? ~x : x ^ {1'b1, {(DATA_WIDTH-1){1'b0}}};
  endfunction
endpackage

// File: rtl/fp_max_tracker.sv
// fp_max_tracker: running IEEE-754 maximum and its index over a streamed sequence
module fp_max_tracker #(
  parameter int ACT_W      = qlearn_pkg::ACT_W,
  parameter int DATA_WIDTH = qlearn_pkg::DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_max,
  output logic [ACT_W-1:0]      o_arg
);
  import qlearn_pkg::*;

  logic [ACT_W-1:0] idx;
  logic             have;
  logic             take;

  // Strictly-greater replacement keeps the lowest index on ties
  assign take = !have || (fp_key(i_data) > fp_key(o_max));

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_max <= '0;
      o_arg <= '0;
      idx   <= '0;
      have  <= 1'b0;
    end else if (i_clear) begin
      idx  <= '0;
      have <= 1'b0;
    end else if (i_valid) begin
      idx  <= idx + 1'b1;
      have <= 1'b1;
      if (take) begin
        o_max <= i_data;
        o_arg <= idx;
      end
    end
endmodule

// File: rtl/qtable_update_ctrl.sv
// qtable_update_ctrl: sequences one Q-learning read/max/update/write-back cycle
// against a single-port-read, single-port-write Q-table BRAM.
module qtable_update_ctrl #(
  parameter int STATE_W    = qlearn_pkg::STATE_W,
  parameter int ACT_W      = qlearn_pkg::ACT_W,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = qlearn_pkg::DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [STATE_W-1:0]    i_state,
  input  logic [ACT_W-1:0]      i_action,
  input  logic [STATE_W-1:0]    i_next_state,
  output logic [ADDR_WIDTH-1:0] o_q_addr_r,
  output logic                  o_q_read_en,
  input  logic [DATA_WIDTH-1:0] i_q_rdata,
  output logic [ADDR_WIDTH-1:0] o_q_addr_w,
  output logic                  o_q_write_en,
  output logic [DATA_WIDTH-1:0] o_q_wdata,
  output logic                  o_upd_valid,
  input  logic                  i_upd_ready,
  output logic [DATA_WIDTH-1:0] o_q_sa,
  output logic [DATA_WIDTH-1:0] o_q_max_next,
  output logic [ACT_W-1:0]      o_max_action,
  input  logic                  i_res_valid,
  input  logic [DATA_WIDTH-1:0] i_res_data,
  output logic                  o_busy,
  output logic                  o_done
);
  import qlearn_pkg::state_t;
  import qlearn_pkg::S_IDLE;
  import qlearn_pkg::S_RD;
  import qlearn_pkg::S_CAP;
  import qlearn_pkg::S_ISSUE;
  import qlearn_pkg::S_WAIT;
  import qlearn_pkg::S_WR;

  localparam int NA = 1 << ACT_W;

  state_t                  st, nx;
  logic [ACT_W:0]          cnt;
  logic [STATE_W-1:0]      s_q, sn_q;
  logic [ACT_W-1:0]        a_q;
  logic [DATA_WIDTH-1:0]   q_sa, res_q;
  logic                    accept;
  logic [ADDR_WIDTH-1:0]   sa_addr;

  assign accept  = (st == S_IDLE) && i_req_valid;
  assign sa_addr = ADDR_WIDTH'({s_q, a_q});
  assign o_q_sa  = q_sa;

  always_comb begin
    nx = st;
    unique case (st)
      S_IDLE:  nx = i_req_valid ? S_RD : S_IDLE;
      S_RD:    nx = (cnt == (ACT_W+1)'(NA)) ? S_CAP : S_RD;
      S_CAP:   nx = S_ISSUE;
      S_ISSUE: nx = i_upd_ready ? S_WAIT : S_ISSUE;
      S_WAIT:  nx = i_res_valid ? S_WR : S_WAIT;
      S_WR:    nx = S_IDLE;
      default: nx = S_IDLE;
    endcase
    o_req_ready  = (st == S_IDLE);
    o_busy       = (st != S_IDLE);
    o_q_read_en  = (st == S_RD);
    // The first NA reads scan s'; the final read (cnt == NA) fetches Q(s,a)
    o_q_addr_r   = (st != S_RD) ? '0 :
                   cnt[ACT_W] ? sa_addr : ADDR_WIDTH'({sn_q, cnt[ACT_W-1:0]});
    o_upd_valid  = (st == S_ISSUE);
    o_q_write_en = (st == S_WR);
    o_done       = (st == S_WR);
    o_q_addr_w   = (st == S_WR) ? sa_addr : '0;
    o_q_wdata    = (st == S_WR) ? res_q : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      st    <= S_IDLE;
      cnt   <= '0;
      s_q   <= '0;
      sn_q  <= '0;
      a_q   <= '0;
      q_sa  <= '0;
      res_q <= '0;
    end else begin
      st <= nx;
      if (accept) begin
        s_q  <= i_state;
        a_q  <= i_action;
        sn_q <= i_next_state;
        cnt  <= '0;
      end
      if (st == S_RD) cnt <= cnt + 1'b1;
      if (st == S_CAP) q_sa <= i_q_rdata;
      if (st == S_WAIT && i_res_valid) res_q <= i_res_data;
    end

  // Read data lags the address by one cycle, so RD cycles after the first carry s' entries
  fp_max_tracker #(.ACT_W(ACT_W), .DATA_WIDTH(DATA_WIDTH)) u_max (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (accept),
    .i_valid ((st == S_RD) && (cnt != '0)),
    .i_data  (i_q_rdata),
    .o_max   (o_q_max_next),
    .o_arg   (o_max_action)
  );
endmodule

// File: tb/tb_qtable_update_ctrl.sv
// tb_qtable_update_ctrl: directed checks of the Q-table update sequencer with a BRAM model
module tb_qtable_update_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [5:0]  state, next_state;
  logic [1:0]  action;
  logic [8:0]  q_addr_r, q_addr_w;
  logic        q_read_en, q_write_en;
  logic [31:0] q_rdata, q_wdata;
  logic        upd_valid, upd_ready;
  logic [31:0] q_sa, q_max_next;
  logic [1:0]  max_action;
  logic        res_valid;
  logic [31:0] res_data;
  logic        busy, done;

  logic        ld_en = 1'b0;
  logic [8:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic [31:0] mem [0:511];

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (q_read_en) q_rdata <= mem[q_addr_r];
    if (q_write_en) mem[q_addr_w] <= q_wdata;
    if (ld_en) mem[ld_addr] <= ld_data;
  end

  qtable_update_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_state      (state),
    .i_action     (action),
    .i_next_state (next_state),
    .o_q_addr_r   (q_addr_r),
    .o_q_read_en  (q_read_en),
    .i_q_rdata    (q_rdata),
    .o_q_addr_w   (q_addr_w),
    .o_q_write_en (q_write_en),
    .o_q_wdata    (q_wdata),
    .o_upd_valid  (upd_valid),
    .i_upd_ready  (upd_ready),
    .o_q_sa       (q_sa),
    .o_q_max_next (q_max_next),
    .o_max_action (max_action),
    .i_res_valid  (res_valid),
    .i_res_data   (res_data),
    .o_busy       (busy),
    .o_done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [8:0] a, input logic [31:0] d);
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_en = 1'b0;
  endtask

  task automatic start(input logic [5:0] s, input logic [1:0] a, input logic [5:0] sn);
    state = s;
    action = a;
    next_state = sn;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    state = '0;
    action = '0;
    next_state = '0;
    q_rdata = '0;
    upd_ready = 1'b0;
    res_valid = 1'b0;
    res_data = '0;
    step();
    load(9'd20, 32'h3F800000); load(9'd21, 32'h40800000);
    load(9'd22, 32'h40000000); load(9'd23, 32'hC0400000);
    load(9'd14, 32'h3F000000);
    load(9'd40, 32'hC0000000); load(9'd41, 32'hBF800000);
    load(9'd42, 32'hBF800000); load(9'd43, 32'hC0A00000);
    load(9'd4,  32'h3E800000);
    load(9'd44, 32'h80000000); load(9'd45, 32'h00000000);
    load(9'd46, 32'h80000000); load(9'd47, 32'h80000000);
    load(9'd9,  32'h41200000);
    load(9'd16, 32'h40A00000);
    load(9'd28, 32'h3F800000); load(9'd29, 32'h40000000);
    load(9'd30, 32'h3F000000); load(9'd31, 32'h40400000);
    load(9'd25, 32'h3DCCCCCD);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_read_en", q_read_en, 0);
    chk("rst_addr_r", q_addr_r, 0);
    chk("rst_write_en", q_write_en, 0);
    chk("rst_done", done, 0);
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_q_max", q_max_next, 0);
    chk("rst_q_sa", q_sa, 0);
    rst_n = 1'b1;
    step();

    // basic update, immediate ready and result
    upd_ready = 1'b1; res_valid = 1'b1; res_data = 32'h3FC00000;
    start(6'd3, 2'd2, 6'd5);
    chk("b_c1_read_en", q_read_en, 1);
    chk("b_c1_addr_r", q_addr_r, 9'd20);
    chk("b_c1_req_ready", req_ready, 0);
    chk("b_c1_busy", busy, 1);
    step(4);
    chk("b_c5_addr_r", q_addr_r, 9'd14);
    step();
    chk("b_c6_read_en", q_read_en, 0);
    step();
    chk("b_c7_upd_valid", upd_valid, 1);
    chk("b_q_sa", q_sa, 32'h3F000000);
    chk("b_q_max", q_max_next, 32'h40800000);
    chk("b_max_act", max_action, 1);
    step();
    chk("b_c8_done", done, 0);
    step();
    chk("b_c9_write_en", q_write_en, 1);
    chk("b_c9_addr_w", q_addr_w, 9'h0E);
    chk("b_c9_wdata", q_wdata, 32'h3FC00000);
    chk("b_c9_done", done, 1);
    step();
    chk("b_c10_done", done, 0);
    chk("b_c10_req_ready", req_ready, 1);
    chk("b_mem14", mem[14], 32'h3FC00000);

    // all-negative with a tie
    res_data = 32'h40400000;
    start(6'd1, 2'd0, 6'd10);
    step(6);
    chk("n_q_max", q_max_next, 32'hBF800000);
    chk("n_max_act", max_action, 1);
    chk("n_q_sa", q_sa, 32'h3E800000);
    step(2);
    chk("n_done", done, 1);
    step();

    // signed zero
    res_data = 32'h41300000;
    start(6'd2, 2'd1, 6'd11);
    step(6);
    chk("z_q_max", q_max_next, 32'h00000000);
    chk("z_max_act", max_action, 1);
    chk("z_q_sa", q_sa, 32'h41200000);
    step(2);
    chk("z_addr_w", q_addr_w, 9'd9);
    step();
    chk("z_mem9", mem[9], 32'h41300000);

    // backpressure with an early result that must be ignored
    upd_ready = 1'b0; res_valid = 1'b1; res_data = 32'h12345678;
    start(6'd4, 2'd0, 6'd5);
    step(6);
    chk("p_c7_upd_valid", upd_valid, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("p_hold_upd_valid", upd_valid, 1);
      chk("p_hold_q_sa", q_sa, 32'h40A00000);
      chk("p_hold_q_max", q_max_next, 32'h40800000);
      chk("p_hold_max_act", max_action, 1);
      chk("p_hold_write_en", q_write_en, 0);
      chk("p_hold_req_ready", req_ready, 0);
    end
    res_valid = 1'b0; upd_ready = 1'b1;
    step();
    chk("p_wait_upd_valid", upd_valid, 0);
    chk("p_wait_write_en", q_write_en, 0);
    chk("p_wait_busy", busy, 1);
    step(2);
    chk("p_wait2_write_en", q_write_en, 0);
    chk("p_wait2_req_ready", req_ready, 0);
    res_valid = 1'b1; res_data = 32'h40E00000;
    step();
    chk("p_write_en", q_write_en, 1);
    chk("p_addr_w", q_addr_w, 9'h10);
    chk("p_wdata", q_wdata, 32'h40E00000);
    step();
    chk("p_mem16", mem[16], 32'h40E00000);

    // self-loop and back-to-back requests
    res_data = 32'h40800000;
    start(6'd7, 2'd3, 6'd7);
    chk("l_c1_addr_r", q_addr_r, 9'd28);
    step(4);
    chk("l_c5_addr_r", q_addr_r, 9'd31);
    step(2);
    chk("l_q_max", q_max_next, 32'h40400000);
    chk("l_max_act", max_action, 3);
    chk("l_q_sa", q_sa, 32'h40400000);
    step(2);
    chk("l_done", done, 1);
    chk("l_addr_w", q_addr_w, 9'd31);
    chk("l_wdata", q_wdata, 32'h40800000);
    res_data = 32'h40A00000;
    step();
    chk("l_c10_req_ready", req_ready, 1);
    start(6'd7, 2'd3, 6'd7);
    step(6);
    chk("l2_q_max", q_max_next, 32'h40800000);
    chk("l2_max_act", max_action, 3);
    chk("l2_q_sa", q_sa, 32'h40800000);
    step(2);
    chk("l2_done", done, 1);
    chk("l2_wdata", q_wdata, 32'h40A00000);
    step();

    // reset while waiting for the result
    res_valid = 1'b0;
    start(6'd6, 2'd1, 6'd5);
    step(7);
    chk("r_wait_busy", busy, 1);
    chk("r_wait_upd_valid", upd_valid, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("r_async_req_ready", req_ready, 1);
    chk("r_async_busy", busy, 0);
    res_valid = 1'b1; res_data = 32'hFFFFFFFF;
    step();
    chk("r_in_rst_write_en", q_write_en, 0);
    rst_n = 1'b1;
    step();
    chk("r_post_write_en", q_write_en, 0);
    chk("r_post_req_ready", req_ready, 1);
    chk("r_mem25", mem[25], 32'h3DCCCCCD);
    res_valid = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
